// File: rtl/uart_msg_rx_pkg.sv
// ============================================================================
// uart_msg_rx_pkg : message geometry constants and assembly FSM states
// Revision 1.0
// ============================================================================
`default_nettype none

package uart_msg_rx_pkg;

  localparam int UART_HEADER_SIZE  = 8;
  localparam int UART_PAYLOAD_SIZE = 64;
  localparam int UART_MSG_SIZE     = UART_HEADER_SIZE + UART_PAYLOAD_SIZE;
  localparam int UART_MSG_BYTES    = UART_MSG_SIZE / 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PUSH    = 2'd2
  } asm_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_msg_rx_if.sv
// ============================================================================
// uart_msg_rx_if : message FIFO handshake towards the controller
// Revision 1.0
// ============================================================================
`default_nettype none

interface uart_msg_rx_if;
  import uart_msg_rx_pkg::*;

  logic                     uart_in_avail;
  logic                     uart_in_req;
  logic [UART_MSG_SIZE-1:0] uart_in_msg;
  logic                     uart_in_full;

  // master: message source (uart_msg_rx); slave: consumer (controller)
  modport master (
    output uart_in_avail,
    input  uart_in_req,
    output uart_in_msg,
    output uart_in_full
  );

  modport slave (
    input  uart_in_avail,
    output uart_in_req,
    input  uart_in_msg,
    input  uart_in_full
  );

endinterface

`default_nettype wire

// File: rtl/uart_msg_rx_msg_fifo.sv
// ============================================================================
// msg_fifo : synchronous FIFO, simultaneous push/pop allowed even when full
// Revision 1.0
// ============================================================================
`default_nettype none

module msg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 72
) (
  input  wire logic                   clk,
  input  wire logic                   n_reset,
  input  wire logic                   push,
  input  wire logic                   pop,
  input  wire logic [WIDTH-1:0]       wdata,
  output logic      [WIDTH-1:0]       rdata,
  output logic      [$clog2(DEPTH):0] count
);

  localparam int                PTR_W  = $clog2(DEPTH);
  localparam int                CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0]  C_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_do_pop  = pop && (r_count != '0);
  // A full FIFO still accepts a write when a pop frees the head slot this cycle
  assign w_do_push = push && ((r_count != C_FULL) || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/uart_msg_rx.sv
// ============================================================================
// uart_msg_rx : assembles UART bytes into header+payload messages and queues them
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_msg_rx
  import uart_msg_rx_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MSG_BYTES      = UART_MSG_BYTES
) (
  input  wire logic       clk,
  input  wire logic       n_reset,
  input  wire logic       rx_valid,
  input  wire logic [7:0] rx_data,
  output logic            rx_discard,
  uart_msg_rx_if.master   uart_in
);

  localparam int                 IDX_W    = $clog2(MSG_BYTES);
  localparam int                 IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int                 CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(MSG_BYTES - 1);
  localparam logic [IDLE_W-1:0]  IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0]  IDLE_PRE = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   C_FULL   = CNT_W'(DEPTH);

  asm_state_t               r_state;
  logic [IDX_W-1:0]         r_idx;
  logic [IDLE_W-1:0]        r_idle;
  logic [UART_MSG_SIZE-1:0] r_shift;
  logic                     r_discard;
  logic [UART_MSG_SIZE-1:0] r_msg;
  logic [UART_MSG_SIZE-1:0] w_head;
  logic [CNT_W-1:0]         w_count;
  logic                     w_pop;

  // Assembly FSM; PUSH accepts a new header byte so back-to-back streams lose nothing
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_idle    <= '0;
      r_shift   <= '0;
      r_discard <= 1'b0;
    end else begin
      r_discard <= 1'b0;
      case (r_state)
        ST_IDLE, ST_PUSH: begin
          r_idle <= '0;
          if (rx_valid) begin
            r_shift <= {{(UART_MSG_SIZE-8){1'b0}}, rx_data};
            r_idx   <= IDX_W'(1);
            r_state <= ST_COLLECT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_COLLECT: begin
          if (rx_valid) begin
            r_shift[{r_idx, 3'b000} +: 8] <= rx_data;
            r_idx  <= r_idx + IDX_W'(1);
            r_idle <= '0;
            if (r_idx == LAST_IDX) begin
              r_state <= ST_PUSH;
            end
          end else if (r_idle == IDLE_PRE) begin
            r_idle    <= IDLE_MAX;
            r_shift   <= '0;
            r_idx     <= '0;
            r_discard <= 1'b1;
            r_state   <= ST_IDLE;
          end else if (r_idle != IDLE_MAX) begin
            r_idle <= r_idle + IDLE_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
          r_idle  <= '0;
        end
      endcase
    end
  end

  assign w_pop = uart_in.uart_in_req && (w_count != '0);

  msg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_MSG_SIZE)
  ) u_msg_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (r_state == ST_PUSH),
    .pop     (w_pop),
    .wdata   (r_shift),
    .rdata   (w_head),
    .count   (w_count)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_msg <= '0;
    end else if (w_pop) begin
      r_msg <= w_head;
    end
  end

  assign uart_in.uart_in_msg   = r_msg;
  assign uart_in.uart_in_avail = (w_count != '0);
  assign uart_in.uart_in_full  = (w_count == C_FULL);
  assign rx_discard            = r_discard;

endmodule

`default_nettype wire

// File: tb/tb_uart_msg_rx.sv
// ============================================================================
// tb_uart_msg_rx : directed + randomized bench with a queue-based reference model
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_msg_rx;
  import uart_msg_rx_pkg::*;

  localparam int DEPTH = 4;
  localparam int TO    = 20;
  localparam int NB    = 9;

  logic       clk      = 1'b0;
  logic       n_reset  = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_discard;

  uart_msg_rx_if bus();

  uart_msg_rx #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TO),
    .MSG_BYTES      (NB)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_discard (rx_discard),
    .uart_in    (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte list, message queue, last popped message
  logic [7:0]  m_bytes [$];
  logic [71:0] m_fifo  [$];
  logic [71:0] m_msg      = '0;
  logic [71:0] m_pend_msg = '0;
  bit          m_pend     = 0;
  bit          m_discard  = 0;
  int          m_gap      = 0;

  initial forever begin
    @(posedge clk or negedge n_reset);
    if (!n_reset) begin
      m_bytes.delete();
      m_fifo.delete();
      m_msg     = '0;
      m_pend    = 0;
      m_discard = 0;
      m_gap     = 0;
    end else begin
      int pre;
      bit do_pop;
      pre    = m_fifo.size();
      do_pop = bus.uart_in_req && (pre != 0);
      if (do_pop) m_msg = m_fifo.pop_front();
      if (m_pend && (pre < DEPTH || do_pop)) m_fifo.push_back(m_pend_msg);
      m_pend    = 0;
      m_discard = 0;
      if (rx_valid) begin
        m_bytes.push_back(rx_data);
        m_gap = 0;
        if (m_bytes.size() == NB) begin
          for (int k = 0; k < NB; k++) m_pend_msg[8*k +: 8] = m_bytes[k];
          m_pend = 1;
          m_bytes.delete();
        end
      end else if (m_bytes.size() != 0) begin
        m_gap++;
        if (m_gap == TO) begin
          m_discard = 1;
          m_bytes.delete();
          m_gap = 0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("avail",   72'(bus.uart_in_avail), 72'(m_fifo.size() != 0));
    chk("full",    72'(bus.uart_in_full),  72'(m_fifo.size() == DEPTH));
    chk("msg",     bus.uart_in_msg,        m_msg);
    chk("discard", 72'(rx_discard),        72'(m_discard));
  end

  // Drive one cycle's inputs; returns 1ns after the sampling edge
  task automatic step(input bit v, input logic [7:0] d, input bit r);
    rx_valid        = v;
    rx_data         = d;
    bus.uart_in_req = r;
    @(posedge clk);
    #1;
    rx_valid        = 1'b0;
    bus.uart_in_req = 1'b0;
  endtask

  task automatic send_msg(input logic [71:0] m);
    for (int k = 0; k < NB; k++) step(1'b1, m[8*k +: 8], 1'b0);
  endtask

  function automatic logic [71:0] rand_msg();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  logic [71:0] msgs [6];
  logic [71:0] last;
  int          pulses;
  int          gap;

  initial begin
    bus.uart_in_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_avail", 72'(bus.uart_in_avail), 72'd0);
    chk("reset_full",  72'(bus.uart_in_full),  72'd0);
    chk("reset_msg",   bus.uart_in_msg,        72'd0);
    n_reset = 1'b1;
    step(1'b0, 8'h00, 1'b0);

    // 1: single message, two-edge latency to avail
    send_msg(72'h887766554433221101);
    chk("t1_avail_early", 72'(bus.uart_in_avail), 72'd0);
    step(1'b0, 8'h00, 1'b0);
    chk("t1_avail", 72'(bus.uart_in_avail), 72'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("t1_msg",   bus.uart_in_msg,        72'h887766554433221101);
    chk("t1_empty", 72'(bus.uart_in_avail), 72'd0);

    // 2: fill and overflow
    for (int i = 0; i < 5; i++) begin
      msgs[i] = rand_msg();
      send_msg(msgs[i]);
      if (i == 3) begin
        step(1'b0, 8'h00, 1'b0);
        chk("t2_full4", 72'(bus.uart_in_full), 72'd1);
      end
    end
    repeat (2) step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("t2_pop", bus.uart_in_msg, msgs[i]);
      if (i == 0) chk("t2_full_fall", 72'(bus.uart_in_full), 72'd0);
    end
    chk("t2_empty", 72'(bus.uart_in_avail), 72'd0);

    // 3: push/pop collision while full
    for (int i = 0; i < 4; i++) begin
      msgs[i] = rand_msg();
      send_msg(msgs[i]);
    end
    msgs[4] = rand_msg();
    send_msg(msgs[4]);
    step(1'b0, 8'h00, 1'b1);
    chk("t3_coll_msg",  bus.uart_in_msg,       msgs[0]);
    chk("t3_coll_full", 72'(bus.uart_in_full), 72'd1);
    for (int i = 1; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("t3_pop", bus.uart_in_msg, msgs[i]);
    end
    chk("t3_empty", 72'(bus.uart_in_avail), 72'd0);

    // 4: timeout resync
    for (int k = 0; k < 5; k++) step(1'b1, 8'($urandom), 1'b0);
    pulses = 0;
    for (int k = 0; k < TO + 2; k++) begin
      step(1'b0, 8'h00, 1'b0);
      if (rx_discard) pulses++;
    end
    chk("t4_pulses", 72'(pulses), 72'd1);
    msgs[5] = rand_msg();
    send_msg(msgs[5]);
    repeat (2) step(1'b0, 8'h00, 1'b0);
    chk("t4_avail", 72'(bus.uart_in_avail), 72'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("t4_msg",   bus.uart_in_msg,        msgs[5]);
    chk("t4_empty", 72'(bus.uart_in_avail), 72'd0);

    // 5: asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) begin
      msgs[i] = rand_msg();
      send_msg(msgs[i]);
    end
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, 8'($urandom), 1'b0);
    #3;
    n_reset = 1'b0;
    #1;
    chk("t5_avail",   72'(bus.uart_in_avail), 72'd0);
    chk("t5_full",    72'(bus.uart_in_full),  72'd0);
    chk("t5_msg",     bus.uart_in_msg,        72'd0);
    chk("t5_discard", 72'(rx_discard),        72'd0);
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    msgs[3] = rand_msg();
    send_msg(msgs[3]);
    repeat (2) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("t5_msg_after", bus.uart_in_msg,        msgs[3]);
    chk("t5_empty",     72'(bus.uart_in_avail), 72'd0);

    // 6: request while empty
    last = bus.uart_in_msg;
    step(1'b0, 8'h00, 1'b1);
    chk("t6_msg",   bus.uart_in_msg,        last);
    chk("t6_avail", 72'(bus.uart_in_avail), 72'd0);

    // Randomized traffic with idle gaps straddling the timeout boundary
    gap = 0;
    for (int i = 0; i < 4000; i++) begin
      bit v;
      bit r;
      if (gap == 0 && $urandom_range(0, 59) == 0) gap = $urandom_range(TO - 2, TO + 3);
      if (gap > 0) begin
        gap--;
        v = 1'b0;
      end else begin
        v = ($urandom_range(0, 9) < 7);
      end
      r = (i < 2000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0);
      step(v, 8'($urandom), r);
    end
    repeat (3) step(1'b0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
